// File: rtl/status_readout.sv
// -----------------------------------------------------------------------------
// status_readout
//
// Fetches one 16-bit status word from the status block on request from the NI
// command decoder, then streams it to the NI interface as two bytes, msb
// first, lsb flagged with tx_last.
//
// Ports
//   clk        master clock, all logic on the rising edge
//   rst_n      synchronous, active-low reset
//   req        status read request (ignored while busy)
//   req_addr   status word address, captured with req
//   stat_addr  address presented to the status block
//   stat_en    one-cycle enable strobe to the status block
//   stat_msb   status high byte (status block updates it on the falling edge)
//   stat_lsb   status low byte  (status block updates it on the falling edge)
//   tx_data    byte to the NI interface
//   tx_valid   tx_data is valid
//   tx_ready   NI interface accepts the current byte
//   tx_last    marks the second (lsb) byte
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse after the lsb byte is accepted
//   addr_err   one-cycle pulse when the request address is outside 0x21..0x29
//   timeout    one-cycle pulse when a byte waited too long and was dropped
//   fsm_state  current FSM state, for debug and checkers
//
// Handshake: a byte transfers on a rising edge where tx_valid and tx_ready are
// both high. While tx_valid is high and tx_ready is low, tx_data and tx_last
// hold their values. tx_ready has no effect while tx_valid is low.
// -----------------------------------------------------------------------------
module status_readout #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [5:0] req_addr,
  output logic [5:0] stat_addr,
  output logic       stat_en,
  input  logic [7:0] stat_msb,
  input  logic [7:0] stat_lsb,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       busy,
  output logic       done,
  output logic       addr_err,
  output logic       timeout,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_WAIT     = 3'd2,
    S_SEND_MSB = 3'd3,
    S_SEND_LSB = 3'd4
  } state_t;

  // Abort fires on the edge where a stalled byte would bring the counter up
  // to TIMEOUT, i.e. when it already holds TIMEOUT-1 and tx_ready is low.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       settle;     // second WAIT cycle reached
  logic [7:0] hold_lsb;   // lsb captured with the msb; msb lives in tx_data
  logic [7:0] wait_cnt;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      settle    <= 1'b0;
      hold_lsb  <= 8'h00;
      wait_cnt  <= 8'h00;
      stat_addr <= 6'h00;
      stat_en   <= 1'b0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      timeout  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            state     <= S_LATCH;
            stat_addr <= req_addr;
            stat_en   <= 1'b1;
            busy      <= 1'b1;
            // Out-of-range addresses still run the full sequence; the status
            // block answers them with zeros.
            addr_err  <= (req_addr < 6'h21) || (req_addr > 6'h29);
          end
        end

        S_LATCH: begin
          state   <= S_WAIT;
          stat_en <= 1'b0;
          settle  <= 1'b0;
        end

        S_WAIT: begin
          // The status block samples the enable and then refreshes its bytes
          // on a falling edge, so give it two full cycles before capturing.
          if (settle) begin
            state    <= S_SEND_MSB;
            settle   <= 1'b0;
            tx_data  <= stat_msb;
            hold_lsb <= stat_lsb;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            wait_cnt <= 8'h00;
          end else begin
            settle <= 1'b1;
          end
        end

        S_SEND_MSB, S_SEND_LSB: begin
          if (tx_valid && tx_ready) begin
            wait_cnt <= 8'h00;
            if (state == S_SEND_MSB) begin
              state   <= S_SEND_LSB;
              tx_data <= hold_lsb;
              tx_last <= 1'b1;
            end else begin
              state    <= S_IDLE;
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else if (wait_cnt == TMO_LAST) begin
            state    <= S_IDLE;
            wait_cnt <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          state    <= S_IDLE;
          stat_en  <= 1'b0;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_readout.sv
// -----------------------------------------------------------------------------
// tb_status_readout
//
// Directed bench for status_readout: a table of complete read transfers applied
// back-to-back, plus hand-written sequences for the timeout abort, reset during
// the lsb byte, and request handling around reset. A small status-block model
// answers stat_en on the falling edge; a scoreboard queue holds the expected
// {tx_last, tx_data} of every byte the NI side should accept.
// -----------------------------------------------------------------------------
module tb_status_readout;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [5:0] req_addr = 6'h00;
  logic [5:0] stat_addr;
  logic       stat_en;
  logic [7:0] stat_msb = 8'h00;
  logic [7:0] stat_lsb = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       tx_last;
  logic       busy;
  logic       done;
  logic       addr_err;
  logic       timeout;
  logic [2:0] fsm_state;

  status_readout #(.TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .stat_addr (stat_addr),
    .stat_en   (stat_en),
    .stat_msb  (stat_msb),
    .stat_lsb  (stat_lsb),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err),
    .timeout   (timeout),
    .fsm_state (fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- status block model ----------------
  logic [7:0] model_msb = 8'h00;
  logic [7:0] model_lsb = 8'h00;
  logic       scramble  = 1'b0;

  always @(negedge clk) begin
    if (stat_en) begin
      if (stat_addr >= 6'h21 && stat_addr <= 6'h29) begin
        stat_msb = model_msb;
        stat_lsb = model_lsb;
      end else begin
        stat_msb = 8'h00;
        stat_lsb = 8'h00;
      end
    end else if (scramble) begin
      // Once the word is captured the live inputs must no longer matter.
      stat_msb = 8'($urandom_range(0, 255));
      stat_lsb = 8'($urandom_range(0, 255));
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : sb
    logic [8:0] e;
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got last=%0b data=0x%0h expected none", tx_last, tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, e});
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0] addr;
    logic [7:0] msb;
    logic [7:0] lsb;
    int         wait_m;
    int         wait_l;
    logic       poke;
    logic       exp_err;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[9];

  // One full transfer. Returns with done visible; the caller's next request
  // may be issued immediately (back-to-back).
  task automatic run_xfer(input vec_t v);
    model_msb = v.msb;
    model_lsb = v.lsb;
    scramble  = 1'b0;
    exp_q.push_back({1'b0, v.exp_msb});
    exp_q.push_back({1'b1, v.exp_lsb});
    // Early ready exercises "ignored outside SEND states".
    tx_ready  = (v.wait_m == 0);
    req       = 1'b1;
    req_addr  = v.addr;
    cyc();                                        // edge N
    req       = 1'b0;
    req_addr  = 6'h3f;
    check("latch_stat_en",   stat_en,   1);
    check("latch_stat_addr", stat_addr, v.addr);
    check("latch_addr_err",  addr_err,  v.exp_err);
    check("latch_busy",      busy,      1);
    check("latch_done",      done,      0);
    check("latch_tx_valid",  tx_valid,  0);
    cyc();                                        // N+1
    check("wait_stat_en",    stat_en,   0);
    check("wait_addr_err",   addr_err,  0);
    check("wait_tx_valid",   tx_valid,  0);
    cyc();                                        // N+2
    check("wait2_tx_valid",  tx_valid,  0);
    cyc();                                        // N+3
    check("msb_valid", tx_valid, 1);
    check("msb_data",  tx_data,  v.exp_msb);
    check("msb_last",  tx_last,  0);
    scramble = 1'b1;
    if (v.poke) begin
      req      = 1'b1;
      req_addr = 6'h22;
    end
    tx_ready = 1'b0;
    for (int i = 0; i < v.wait_m; i++) begin
      cyc();
      check("msb_hold", {tx_valid, tx_last, timeout, tx_data}, {1'b1, 1'b0, 1'b0, v.exp_msb});
    end
    req      = 1'b0;
    tx_ready = 1'b1;
    cyc();                                        // msb accepted
    check("lsb_valid", tx_valid, 1);
    check("lsb_data",  tx_data,  v.exp_lsb);
    check("lsb_last",  tx_last,  1);
    check("lsb_busy",  busy,     1);
    check("lsb_stat_en", stat_en, 0);
    tx_ready = 1'b0;
    for (int i = 0; i < v.wait_l; i++) begin
      cyc();
      check("lsb_hold", {tx_valid, tx_last, timeout, tx_data}, {1'b1, 1'b1, 1'b0, v.exp_lsb});
    end
    tx_ready = 1'b1;
    cyc();                                        // lsb accepted
    tx_ready = 1'b0;
    check("done_pulse",    done,     1);
    check("done_busy",     busy,     0);
    check("done_tx_valid", tx_valid, 0);
    check("done_timeout",  timeout,  0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    //           addr   msb    lsb    wm   wl   poke  err   emsb   elsb
    vecs[0] = '{6'h28, 8'hA5, 8'h3C,   0,   0, 1'b0, 1'b0, 8'hA5, 8'h3C};
    vecs[1] = '{6'h28, 8'hA5, 8'h3C,  10,  10, 1'b0, 1'b0, 8'hA5, 8'h3C};
    vecs[2] = '{6'h05, 8'h77, 8'h88,   0,   0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{6'h21, 8'h12, 8'h34,   1,   0, 1'b0, 1'b0, 8'h12, 8'h34};
    vecs[4] = '{6'h29, 8'hFE, 8'h01,   0,   2, 1'b0, 1'b0, 8'hFE, 8'h01};
    vecs[5] = '{6'h20, 8'h55, 8'h66,   0,   0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{6'h2A, 8'h99, 8'h11,   0,   0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[7] = '{6'h24, 8'hC0, 8'hDE, 254, 254, 1'b0, 1'b0, 8'hC0, 8'hDE};
    vecs[8] = '{6'h26, 8'h0F, 8'hF0,   3,   0, 1'b1, 1'b0, 8'h0F, 8'hF0};

    // Reset with a request pending: request must be discarded.
    rst_n = 1'b0; req = 1'b1; req_addr = 6'h28; tx_ready = 1'b0;
    cyc();
    cyc();
    check("rst_outputs",
          {stat_addr, stat_en, tx_data, tx_valid, tx_last, busy, done, addr_err, timeout, fsm_state},
          32'd0);
    rst_n = 1'b1; req = 1'b0;
    cyc();
    check("rst_release_busy",    busy,    0);
    check("rst_release_stat_en", stat_en, 0);

    // Table: every transfer issued right after the previous done.
    for (int k = 0; k < 9; k++) run_xfer(vecs[k]);

    // The last row poked req during SEND_MSB: nothing may follow it.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("poke_idle", {busy, stat_en, tx_valid, done}, 4'b0000);
    end

    // Timeout: tx_ready never rises.
    model_msb = 8'h11; model_lsb = 8'h22; scramble = 1'b0; tx_ready = 1'b0;
    req = 1'b1; req_addr = 6'h25;
    cyc();
    req = 1'b0;
    cyc();
    cyc();
    cyc();
    check("to_first_valid", tx_valid, 1);
    for (int i = 1; i < 255; i++) begin
      cyc();
      check("to_pending", {tx_valid, timeout, busy}, 3'b101);
    end
    cyc();
    check("to_pulse", {timeout, tx_valid, busy, done}, 4'b1000);
    cyc();
    check("to_after", {timeout, tx_valid, busy, done}, 4'b0000);

    // Reset while the lsb byte is pending.
    model_msb = 8'h5A; model_lsb = 8'hC3; scramble = 1'b0; tx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h5A});
    req = 1'b1; req_addr = 6'h23;
    cyc();
    req = 1'b0;
    cyc();
    cyc();
    cyc();
    check("rl_msb_data", tx_data, 8'h5A);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("rl_in_lsb", {tx_valid, tx_last, tx_data}, {1'b1, 1'b1, 8'hC3});
    cyc();
    rst_n = 1'b0; req = 1'b1; req_addr = 6'h24;
    cyc();
    check("rl_rst_outputs",
          {stat_addr, stat_en, tx_data, tx_valid, tx_last, busy, done, addr_err, timeout, fsm_state},
          32'd0);
    cyc();
    check("rl_rst_busy", busy, 0);
    rst_n = 1'b1; req = 1'b0;
    cyc();
    check("rl_after", {busy, stat_en, done, timeout, tx_valid}, 5'b00000);

    // Fresh transfer after the reset.
    v = '{6'h27, 8'h3E, 8'h81, 2, 1, 1'b0, 1'b0, 8'h3E, 8'h81};
    run_xfer(v);
    cyc();
    check("final_done_clear", done, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/status_readout.md
STATUS_READOUT -- requirements
Module: status_readout

Interface
REQ-001 Parameter TIMEOUT, default 255; max cycles a pending byte waits for tx_ready before abort.
REQ-002 clk  input  1  master fpga clk; all logic on posedge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  1  status read request from NI command decoder, sampled on posedge.
REQ-005 req_addr  input  6  status word address accompanying req.
REQ-006 stat_addr  output  6  address to status block.
REQ-007 stat_en  output  1  enable_cntl strobe to status block.
REQ-008 stat_msb  input  8  status high byte, updated by status block on negedge.
REQ-009 stat_lsb  input  8  status low byte, updated by status block on negedge.
REQ-010 tx_data  output  8  byte to NI interface.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  NI interface accepts byte.
REQ-013 tx_last  output  1  high with second (lsb) byte.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse after lsb byte accepted.
REQ-016 addr_err  output  1  one-cycle pulse on request outside 0x21..0x29.
REQ-017 timeout  output  1  one-cycle pulse on transfer abort.

Function
REQ-018 FSM states: IDLE, LATCH, WAIT, SEND_MSB, SEND_LSB; all outputs registered.
REQ-019 IDLE: req=1 -> LATCH; req_addr captured into stat_addr on same edge.
REQ-020 req while busy=1 is ignored, not queued.
REQ-021 addr outside 0x21..0x29 -> addr_err pulse in LATCH cycle; sequence continues and sends status block's default 0x00/0x00.
REQ-022 LATCH: stat_en=1 for exactly one cycle -> WAIT unconditionally.
REQ-023 WAIT: stat_en=0; at exit edge stat_msb/stat_lsb captured into holding registers -> SEND_MSB.
REQ-024 Holding registers, not live stat_* inputs, source tx_data; later changes on stat_* do not affect the transfer.
REQ-025 SEND_MSB: tx_valid=1, tx_data=held msb, tx_last=0; tx_valid&&tx_ready -> SEND_LSB.
REQ-026 SEND_LSB: tx_valid=1, tx_data=held lsb, tx_last=1; tx_valid&&tx_ready -> IDLE with done=1 next cycle.
REQ-027 tx_data and tx_last stay stable while tx_valid=1 and tx_ready=0.
REQ-028 Latency: req at edge N -> stat_en high cycle N+1 -> tx_valid high from edge N+3; zero-wait transfer gives done at edge N+5.
REQ-029 Back-to-back: req sampled in the IDLE cycle following done is accepted.
REQ-030 Wait counter (8 bits): cleared on entering SEND_MSB and on each accepted byte; increments each SEND cycle with tx_ready=0.
REQ-031 Counter reaching TIMEOUT -> tx_valid drops, timeout pulse, IDLE next edge; no done pulse.
REQ-032 tx_ready asserted on the same edge the counter reaches TIMEOUT: transfer wins, no timeout.
REQ-033 tx_ready outside SEND states is ignored.

Reset
REQ-034 rst_n=0 at a posedge -> state IDLE; stat_addr=0, stat_en=0, tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, addr_err=0, timeout=0; holding regs and counter=0.
REQ-035 Reset in any state, including mid-transfer, aborts without done or timeout pulse; tx_valid low from the next edge.
REQ-036 req asserted during reset is discarded.

Verification
REQ-037 req, req_addr=0x28, stat_msb=0xA5, stat_lsb=0x3C, tx_ready=1 -> stat_en one cycle, stat_addr=0x28, bytes 0xA5 then 0x3C (tx_last=1), done at edge N+5.
REQ-038 Same transfer, tx_ready low 10 cycles per byte -> tx_data held stable, both bytes delivered, no timeout.
REQ-039 tx_ready held low, TIMEOUT=255 -> timeout pulse after 255 wait cycles in SEND_MSB, busy=0 next cycle, no done.
REQ-040 req_addr=0x05 -> addr_err pulse, bytes 0x00,0x00 sent, done asserted.
REQ-041 Second req during SEND_MSB -> ignored, only one two-byte transfer; req after done -> new transfer.
REQ-042 rst_n low during SEND_LSB -> all outputs zero next edge, no done; fresh req afterwards completes normally.
